player_bullet: RTL and testbench

PLAYER_BULLET -- requirements
Module: player_bullet

---
 rtl/player_bullet.sv | 109 ++++++++++
 tb/tb_player_bullet.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/player_bullet.sv
// Player bullet: spawns at the muzzle on a fire press, climbs on move strobes,
// retires on hit or at the top, then waits a frame-counted cooldown.
module player_bullet #(
  parameter int unsigned BULLET_STEP     = 4,
  parameter int unsigned BULLET_TOP      = 16,
  parameter int unsigned MUZZLE_OFFSET   = 8,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame,
  input  logic       clk_move,
  input  logic       fire,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic       hit,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_active,
  output logic       shot_fired
);

  typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_t;

  localparam logic [10:0] RETIRE_Y = 11'(BULLET_TOP + BULLET_STEP);
  localparam logic [9:0]  STEP     = 10'(BULLET_STEP);
  localparam logic [9:0]  OFFSET   = 10'(MUZZLE_OFFSET);
  localparam logic [7:0]  CD_LOAD  = 8'(COOLDOWN_FRAMES);

  state_t     state, state_nxt;
  logic [9:0] pos_x, pos_x_nxt, pos_y, pos_y_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       fire_prev, armed, press, shot_nxt;

  // armed only rises once fire has been seen low after reset, so a button
  // held through reset release cannot look like a fresh press.
  assign press = fire & ~fire_prev & armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pos_x         <= '0;
      pos_y         <= '0;
      cnt           <= '0;
      fire_prev     <= 1'b0;
      armed         <= 1'b0;
      shot_fired    <= 1'b0;
      bullet_x      <= '0;
      bullet_y      <= '0;
      bullet_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      pos_x      <= pos_x_nxt;
      pos_y      <= pos_y_nxt;
      cnt        <= cnt_nxt;
      fire_prev  <= fire;
      armed      <= armed | ~fire;
      shot_fired <= shot_nxt;
      if (frame) begin
        bullet_x      <= pos_x;
        bullet_y      <= pos_y;
        bullet_active <= (state == ACTIVE);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pos_x_nxt = pos_x;
    pos_y_nxt = pos_y;
    cnt_nxt   = cnt;
    shot_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (press) begin
          state_nxt = ACTIVE;
          pos_x_nxt = player_x + OFFSET;
          pos_y_nxt = player_y;
          shot_nxt  = 1'b1;
        end
      end
      ACTIVE: begin
        if (hit) begin
          state_nxt = COOLDOWN;
          cnt_nxt   = CD_LOAD;
        end else if (clk_move) begin
          if ({1'b0, pos_y} >= RETIRE_Y) begin
            pos_y_nxt = pos_y - STEP;
          end else begin
            state_nxt = COOLDOWN;
            cnt_nxt   = CD_LOAD;
          end
        end
      end
      COOLDOWN: begin
        if (frame) begin
          if (cnt <= 8'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_player_bullet.sv
// Bench for player_bullet: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the bullet's life.
module tb_player_bullet;
  localparam int STEP = 4, TOP = 16, OFF = 8, COOL = 8;

  logic       clk = 1'b0, rst = 1'b1, frame = 1'b0, clk_move = 1'b0, fire = 1'b0, hit = 1'b0;
  logic [9:0] player_x = '0, player_y = '0;
  logic [9:0] bullet_x, bullet_y;
  logic       bullet_active, shot_fired;

  int checks = 0, errors = 0;

  // Reference model: a bullet is either alive, or dead with some cooldown frames left.
  bit m_alive, m_prev, m_armed;
  int m_cool, m_x, m_y;
  int e_bx, e_by;
  bit e_ba, e_shot;

  player_bullet #(
    .BULLET_STEP(STEP), .BULLET_TOP(TOP), .MUZZLE_OFFSET(OFF), .COOLDOWN_FRAMES(COOL)
  ) dut (
    .clk(clk), .rst(rst), .frame(frame), .clk_move(clk_move), .fire(fire),
    .player_x(player_x), .player_y(player_y), .hit(hit),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
    .shot_fired(shot_fired)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_alive = 0; m_prev = 0; m_armed = 0; m_cool = 0; m_x = 0; m_y = 0;
    e_bx = 0; e_by = 0; e_ba = 0; e_shot = 0;
  endtask

  task automatic step(input bit f, input bit mv, input bit fi, input bit h);
    bit press;
    @(negedge clk);
    frame = f; clk_move = mv; fire = fi; hit = h;
    @(posedge clk);
    press = fi && !m_prev && m_armed;
    if (f) begin e_bx = m_x; e_by = m_y; e_ba = m_alive; end
    e_shot = 0;
    if (m_alive) begin
      if (h) begin m_alive = 0; m_cool = COOL; end
      else if (mv) begin
        if (m_y >= TOP + STEP) m_y = m_y - STEP;
        else begin m_alive = 0; m_cool = COOL; end
      end
    end else if (m_cool > 0) begin
      if (f) m_cool = m_cool - 1;
    end else if (press) begin
      m_alive = 1; m_x = (int'(player_x) + OFF) % 1024; m_y = int'(player_y); e_shot = 1;
    end
    if (!fi) m_armed = 1;
    m_prev = fi;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_alive || m_cool > 0) && n < 100) begin
      step(1, 0, 0, m_alive);
      n++;
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1; fire = 0; #2;
    model_reset();
    checks++; if (bullet_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", bullet_active); end
    checks++; if (bullet_x !== 10'd0) begin errors++; $display("FAIL reset_x got %0d want 0", bullet_x); end
    checks++; if (bullet_y !== 10'd0) begin errors++; $display("FAIL reset_y got %0d want 0", bullet_y); end
    checks++; if (shot_fired !== 1'b0) begin errors++; $display("FAIL reset_shot got %b want 0", shot_fired); end
    @(negedge clk); rst = 0;
    step(0, 0, 0, 0);
  endtask

  task automatic test_spawn();
    player_x = 10'd100; player_y = 10'd440;
    step(0, 0, 1, 0);
    checks++; if (shot_fired !== 1'b1) begin errors++; $display("FAIL spawn_shot got %b want 1", shot_fired); end
    step(0, 0, 1, 0);
    checks++; if (shot_fired !== 1'b0) begin errors++; $display("FAIL spawn_shot_once got %b want 0", shot_fired); end
    step(1, 0, 1, 0);
    checks++; if (bullet_active !== 1'b1) begin errors++; $display("FAIL spawn_active got %b want 1", bullet_active); end
    checks++; if (bullet_x !== 10'd108) begin errors++; $display("FAIL spawn_x got %0d want 108", bullet_x); end
    checks++; if (bullet_y !== 10'd440) begin errors++; $display("FAIL spawn_y got %0d want 440", bullet_y); end
  endtask

  task automatic test_flight();
    bit extra = 0;
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, i[0], 0);
      if (shot_fired !== 1'b0) extra = 1;
    end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL flight_no_refire got %b want 0", extra); end
    step(1, 0, 0, 0);
    checks++; if (bullet_y !== 10'd400) begin errors++; $display("FAIL flight_y got %0d want 400", bullet_y); end
    checks++; if (bullet_x !== 10'd108) begin errors++; $display("FAIL flight_x got %0d want 108", bullet_x); end
    drain();
  endtask

  task automatic test_top_cooldown();
    player_x = 10'd50; player_y = 10'd21;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    checks++; if (bullet_y !== 10'd17) begin errors++; $display("FAIL top_step_y got %0d want 17", bullet_y); end
    checks++; if (bullet_active !== 1'b1) begin errors++; $display("FAIL top_active got %b want 1", bullet_active); end
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    checks++; if (bullet_active !== 1'b0) begin errors++; $display("FAIL top_retired got %b want 0", bullet_active); end
    checks++; if (bullet_y !== 10'd17) begin errors++; $display("FAIL top_no_underflow got %0d want 17", bullet_y); end
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    checks++; if (shot_fired !== 1'b0) begin errors++; $display("FAIL cooldown_7_discard got %b want 0", shot_fired); end
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    checks++; if (shot_fired !== 1'b1) begin errors++; $display("FAIL cooldown_8_refire got %b want 1", shot_fired); end
    drain();
  endtask

  task automatic test_hit_priority();
    player_x = 10'd200; player_y = 10'd300;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    step(1, 0, 0, 0);
    checks++; if (bullet_active !== 1'b0) begin errors++; $display("FAIL hit_active got %b want 0", bullet_active); end
    checks++; if (bullet_y !== 10'd300) begin errors++; $display("FAIL hit_y got %0d want 300", bullet_y); end
    drain();
  endtask

  task automatic test_reset_fire();
    bit seen = 0;
    player_x = 10'd10; player_y = 10'd200;
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    @(negedge clk); rst = 1; #2; model_reset();
    checks++; if (bullet_active !== 1'b0) begin errors++; $display("FAIL midflight_reset got %b want 0", bullet_active); end
    @(negedge clk); rst = 0;
    for (int i = 0; i < 4; i++) begin
      step(i == 2, 0, 1, 0);
      if (shot_fired !== 1'b0) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL held_fire_reset got %b want 0", seen); end
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    checks++; if (shot_fired !== 1'b1) begin errors++; $display("FAIL repress_after_reset got %b want 1", shot_fired); end
    drain();
  endtask

  task automatic test_frame_press();
    player_x = 10'd1020; player_y = 10'd99;
    step(1, 0, 1, 0);
    checks++; if (shot_fired !== 1'b1) begin errors++; $display("FAIL framepress_shot got %b want 1", shot_fired); end
    checks++; if (bullet_active !== 1'b0) begin errors++; $display("FAIL framepress_preedge got %b want 0", bullet_active); end
    step(1, 0, 0, 0);
    checks++; if (bullet_active !== 1'b1) begin errors++; $display("FAIL framepress_next got %b want 1", bullet_active); end
    checks++; if (bullet_x !== 10'd4) begin errors++; $display("FAIL framepress_wrap_x got %0d want 4", bullet_x); end
    drain();
  endtask

  task automatic test_random();
    bit fi = 0;
    for (int i = 0; i < 3000; i++) begin
      bit f, mv, h;
      f  = ($urandom_range(0, 5) == 0);
      mv = ($urandom_range(0, 2) == 0);
      h  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) fi = ~fi;
      if (f) begin
        player_x = 10'($urandom);
        player_y = 10'($urandom_range(0, 479));
      end
      step(f, mv, fi, h);
      checks++; if (int'(bullet_x) !== e_bx) begin errors++; $display("FAIL rand_x cyc %0d got %0d want %0d", i, bullet_x, e_bx); end
      checks++; if (int'(bullet_y) !== e_by) begin errors++; $display("FAIL rand_y cyc %0d got %0d want %0d", i, bullet_y, e_by); end
      checks++; if (bullet_active !== e_ba) begin errors++; $display("FAIL rand_active cyc %0d got %b want %b", i, bullet_active, e_ba); end
      checks++; if (shot_fired !== e_shot) begin errors++; $display("FAIL rand_shot cyc %0d got %b want %b", i, shot_fired, e_shot); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_spawn();
    test_flight();
    test_top_cooldown();
    test_hit_priority();
    test_reset_fire();
    test_frame_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
